fwrisc_csr_exec: RTL and testbench

- Initiator side of the register-file CSR access interface. Executes one Zicsr instruction per request: CSRRW, CSRRS, CSRRC and their immediate forms.
- Maps the 12-bit CSR address to the 6-bit register-file index, reads the old value and computes the new value.
- Writes the new value to the CSR, then writes the old value to the integer destination register through the single register-file write port.
- Sits between the decode/execute stage and the register file.

---
 rtl/fwrisc_csr_exec_if.sv | 30 +++
 rtl/fwrisc_csr_exec.sv | 213 +++++++++++++++++++++
 tb/tb_fwrisc_csr_exec.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fwrisc_csr_exec_if.sv
// Bundle of request, register-file and response signals around the CSR executor.
// The master modport is the executor's view; slave is the surrounding pipeline/register file.
interface fwrisc_csr_exec_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_csr;
  logic [4:0]  req_rs1;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rd;
  logic [5:0]  csr_raddr;
  logic [31:0] csr_rdata;
  logic [5:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        rd_wen;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_illegal;
  logic        instr_complete;

  modport master (
    input  req_valid, req_op, req_csr, req_rs1, req_rs1_data, req_rd, csr_rdata, rsp_ready,
    output req_ready, csr_raddr, rd_waddr, rd_wdata, rd_wen, rsp_valid, rsp_illegal, instr_complete
  );

  modport slave (
    output req_valid, req_op, req_csr, req_rs1, req_rs1_data, req_rd, csr_rdata, rsp_ready,
    input  req_ready, csr_raddr, rd_waddr, rd_wdata, rd_wen, rsp_valid, rsp_illegal, instr_complete
  );
endinterface

// File: rtl/fwrisc_csr_exec.sv
// Zicsr executor: reads a CSR from the register file, writes the new CSR value, then the old value to rd.
// Optional macro FWRISC_CSR_ROCHECK_EN enables flagging writes to read-only CSRs as illegal.
module fwrisc_csr_exec #(
  parameter bit RO_ILLEGAL = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  fwrisc_csr_exec_if.master     bus
);

`ifdef FWRISC_CSR_ROCHECK_EN
  localparam bit ROCHECK_ON = 1'b1;
`else
  localparam bit ROCHECK_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WCSR = 3'd2,
    WGPR = 3'd3,
    RESP = 3'd4
  } state_t;

  // Unmapped addresses return index 0, which no real CSR uses.
  function automatic logic [5:0] csr_index(input logic [11:0] addr);
    case (addr)
      12'hB00: csr_index = 6'h20;
      12'hB02: csr_index = 6'h21;
      12'hB80: csr_index = 6'h22;
      12'hB82: csr_index = 6'h23;
      12'hF11: csr_index = 6'h24;
      12'hF12: csr_index = 6'h25;
      12'hF13: csr_index = 6'h26;
      12'hF14: csr_index = 6'h27;
      12'h300: csr_index = 6'h28;
      12'h301: csr_index = 6'h29;
      12'h304: csr_index = 6'h2A;
      12'h305: csr_index = 6'h2B;
      12'h340: csr_index = 6'h2C;
      12'h341: csr_index = 6'h2D;
      12'h342: csr_index = 6'h2E;
      12'h343: csr_index = 6'h2F;
      12'h344: csr_index = 6'h30;
      default: csr_index = 6'h00;
    endcase
  endfunction

  state_t      state_r, next_state_s;
  logic [2:0]  op_r;
  logic        csr_ro_r;
  logic [4:0]  rs1_r;
  logic [31:0] rs1_data_r;
  logic [4:0]  rd_r;
  logic [31:0] old_r;

  logic        req_ready_r, req_ready_s;
  logic [5:0]  csr_raddr_r, csr_raddr_s;
  logic [5:0]  rd_waddr_r, rd_waddr_s;
  logic [31:0] rd_wdata_r, rd_wdata_s;
  logic        rd_wen_r, rd_wen_s;
  logic        rsp_valid_r, rsp_valid_s;
  logic        rsp_illegal_r, rsp_illegal_s;
  logic        instr_complete_r, instr_complete_s;

  logic        accept_s;
  logic        rsp_take_s;
  logic [31:0] src_s;
  logic [31:0] new_s;
  logic        do_write_s;
  logic        illegal_s;

  assign accept_s   = bus.req_valid && req_ready_r;
  assign rsp_take_s = bus.rsp_ready && rsp_valid_r;

  // New CSR value, write qualification and legality, all evaluated during READ.
  always_comb begin
    src_s      = op_r[2] ? {27'd0, rs1_r} : rs1_data_r;
    do_write_s = (op_r[1:0] == 2'b01) || (rs1_r != 5'd0);
    case (op_r[1:0])
      2'b01:   new_s = src_s;
      2'b10:   new_s = bus.csr_rdata | src_s;
      2'b11:   new_s = bus.csr_rdata & ~src_s;
      default: new_s = src_s;
    endcase
    illegal_s = (csr_raddr_r == 6'h00) || (op_r[1:0] == 2'b00) ||
                (ROCHECK_ON && RO_ILLEGAL && do_write_s && csr_ro_r);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = READ;
        else          next_state_s = IDLE;
      end
      READ: begin
        if (illegal_s) next_state_s = RESP;
        else           next_state_s = WCSR;
      end
      WCSR: next_state_s = WGPR;
      WGPR: next_state_s = RESP;
      RESP: begin
        if (rsp_take_s) next_state_s = IDLE;
        else            next_state_s = RESP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode: values the output registers take on the next edge.
  always_comb begin
    req_ready_s      = (next_state_s == IDLE);
    rsp_valid_s      = (next_state_s == RESP);
    csr_raddr_s      = csr_raddr_r;
    rd_wen_s         = 1'b0;
    rd_waddr_s       = rd_waddr_r;
    rd_wdata_s       = rd_wdata_r;
    rsp_illegal_s    = rsp_illegal_r;
    instr_complete_s = 1'b0;
    case (state_r)
      IDLE: begin
        rsp_illegal_s = 1'b0;
        if (accept_s) csr_raddr_s = csr_index(bus.req_csr);
        else          csr_raddr_s = csr_raddr_r;
      end
      READ: begin
        if (illegal_s) begin
          rsp_illegal_s = 1'b1;
        end else begin
          rd_wen_s   = do_write_s;
          rd_waddr_s = csr_raddr_r;
          rd_wdata_s = new_s;
        end
      end
      WCSR: begin
        rd_wen_s   = (rd_r != 5'd0);
        rd_waddr_s = {1'b0, rd_r};
        rd_wdata_s = old_r;
      end
      WGPR: rd_wen_s = 1'b0;
      RESP: begin
        if (rsp_take_s) begin
          instr_complete_s = !rsp_illegal_r;
          rsp_illegal_s    = 1'b0;
        end else begin
          instr_complete_s = 1'b0;
        end
      end
      default: rd_wen_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_ready_r      <= 1'b0;
      csr_raddr_r      <= 6'h00;
      rd_waddr_r       <= 6'h00;
      rd_wdata_r       <= 32'h0;
      rd_wen_r         <= 1'b0;
      rsp_valid_r      <= 1'b0;
      rsp_illegal_r    <= 1'b0;
      instr_complete_r <= 1'b0;
    end else begin
      req_ready_r      <= req_ready_s;
      csr_raddr_r      <= csr_raddr_s;
      rd_waddr_r       <= rd_waddr_s;
      rd_wdata_r       <= rd_wdata_s;
      rd_wen_r         <= rd_wen_s;
      rsp_valid_r      <= rsp_valid_s;
      rsp_illegal_r    <= rsp_illegal_s;
      instr_complete_r <= instr_complete_s;
    end
  end

  // Request capture at acceptance and old CSR value capture in READ.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_r       <= 3'd0;
      csr_ro_r   <= 1'b0;
      rs1_r      <= 5'd0;
      rs1_data_r <= 32'h0;
      rd_r       <= 5'd0;
      old_r      <= 32'h0;
    end else if (accept_s) begin
      op_r       <= bus.req_op;
      csr_ro_r   <= (bus.req_csr[11:10] == 2'b11);
      rs1_r      <= bus.req_rs1;
      rs1_data_r <= bus.req_rs1_data;
      rd_r       <= bus.req_rd;
    end else if (state_r == READ) begin
      old_r      <= bus.csr_rdata;
    end
  end

  assign bus.req_ready      = req_ready_r;
  assign bus.csr_raddr      = csr_raddr_r;
  assign bus.rd_waddr       = rd_waddr_r;
  assign bus.rd_wdata       = rd_wdata_r;
  assign bus.rd_wen         = rd_wen_r;
  assign bus.rsp_valid      = rsp_valid_r;
  assign bus.rsp_illegal    = rsp_illegal_r;
  assign bus.instr_complete = instr_complete_r;

endmodule

// File: tb/tb_fwrisc_csr_exec.sv
// Directed self-checking bench for fwrisc_csr_exec with a preloaded register-file read model.
module tb_fwrisc_csr_exec;
  logic clock;
  logic reset;
  int   tests_run;
  int   failed;
  int   cyc;
  int   ccnt;
  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] rf [0:63];

  fwrisc_csr_exec_if ifc ();

  fwrisc_csr_exec dut (.clock(clock), .reset(reset), .bus(ifc));

  assign ifc.csr_rdata = rf[ifc.csr_raddr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Log every register-file write and completion pulse.
  always @(negedge clock) begin
    if (ifc.rd_wen === 1'b1) begin
      wa_q.push_back(ifc.rd_waddr);
      wd_q.push_back(ifc.rd_wdata);
    end
    if (ifc.instr_complete === 1'b1) ccnt = ccnt + 1;
  end

  // Called at a negedge; returns at the first negedge showing rsp_valid.
  task automatic issue(input logic [2:0] op, input logic [11:0] csr, input logic [4:0] rs1,
                       input logic [31:0] d, input logic [4:0] rd, output int lat, output int acc);
    int n;
    ifc.req_op = op; ifc.req_csr = csr; ifc.req_rs1 = rs1; ifc.req_rs1_data = d; ifc.req_rd = rd;
    ifc.req_valid = 1'b1;
    n = 0;
    while (ifc.req_ready !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    tests_run++;
    if (n >= 20) begin failed++; $display("FAIL accept_timeout: req_ready=%b expected 1", ifc.req_ready); end
    @(posedge clock); #1 acc = cyc;
    @(negedge clock); ifc.req_valid = 1'b0; lat = 1;
    while (ifc.rsp_valid !== 1'b1 && lat < 20) begin @(negedge clock); lat++; end
    tests_run++;
    if (lat >= 20) begin failed++; $display("FAIL rsp_timeout: rsp_valid=%b expected 1", ifc.rsp_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests_run++;
    if ({ifc.req_ready, ifc.rd_wen, ifc.rsp_valid, ifc.rsp_illegal, ifc.instr_complete} !== 5'b0) begin
      failed++; $display("FAIL reset_ctrl: got %b expected 00000",
        {ifc.req_ready, ifc.rd_wen, ifc.rsp_valid, ifc.rsp_illegal, ifc.instr_complete});
    end
    tests_run++;
    if ({ifc.csr_raddr, ifc.rd_waddr, ifc.rd_wdata} !== 44'h0) begin
      failed++; $display("FAIL reset_data: got %h expected 0", {ifc.csr_raddr, ifc.rd_waddr, ifc.rd_wdata});
    end
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if (ifc.req_ready !== 1'b1) begin failed++; $display("FAIL reset_idle_ready: got %b expected 1", ifc.req_ready); end
  endtask

  task automatic test_csrrw();
    int lat, acc, b, cb;
    rf[6'h2C] = 32'h11;
    b = wa_q.size(); cb = ccnt;
    issue(3'd1, 12'h340, 5'd7, 32'hDEADBEEF, 5'd5, lat, acc);
    tests_run++; if (lat != 4) begin failed++; $display("FAIL rw_latency: got %0d expected 4", lat); end
    tests_run++; if (ifc.rsp_illegal !== 1'b0) begin failed++; $display("FAIL rw_illegal: got %b expected 0", ifc.rsp_illegal); end
    repeat (2) @(negedge clock);
    tests_run++;
    if (wa_q.size() - b != 2) begin failed++; $display("FAIL rw_wcount: got %0d expected 2", wa_q.size() - b); end
    else begin
      tests_run++;
      if ({wa_q[b], wd_q[b]} !== {6'h2C, 32'hDEADBEEF}) begin failed++; $display("FAIL rw_csr_write: got %h/%h expected 2c/deadbeef", wa_q[b], wd_q[b]); end
      tests_run++;
      if ({wa_q[b+1], wd_q[b+1]} !== {6'h05, 32'h11}) begin failed++; $display("FAIL rw_rd_write: got %h/%h expected 05/00000011", wa_q[b+1], wd_q[b+1]); end
    end
    tests_run++; if (ccnt - cb != 1) begin failed++; $display("FAIL rw_complete: got %0d expected 1", ccnt - cb); end
  endtask

  task automatic test_set_clear();
    int lat, acc, b;
    rf[6'h28] = 32'h80; rf[6'h2D] = 32'hFF; rf[6'h2B] = 32'h100;
    b = wa_q.size();
    issue(3'd2, 12'h300, 5'd3, 32'h8, 5'd3, lat, acc);
    issue(3'd3, 12'h341, 5'd1, 32'hF0, 5'd2, lat, acc);
    issue(3'd6, 12'h305, 5'h1F, 32'hFFFFFFFF, 5'd10, lat, acc);
    repeat (2) @(negedge clock);
    tests_run++;
    if (wa_q.size() - b != 6) begin failed++; $display("FAIL sc_wcount: got %0d expected 6", wa_q.size() - b); end
    else begin
      tests_run++; if ({wa_q[b], wd_q[b]} !== {6'h28, 32'h88}) begin failed++; $display("FAIL rs_csr: got %h/%h expected 28/00000088", wa_q[b], wd_q[b]); end
      tests_run++; if ({wa_q[b+1], wd_q[b+1]} !== {6'h03, 32'h80}) begin failed++; $display("FAIL rs_rd: got %h/%h expected 03/00000080", wa_q[b+1], wd_q[b+1]); end
      tests_run++; if ({wa_q[b+2], wd_q[b+2]} !== {6'h2D, 32'h0F}) begin failed++; $display("FAIL rc_csr: got %h/%h expected 2d/0000000f", wa_q[b+2], wd_q[b+2]); end
      tests_run++; if ({wa_q[b+3], wd_q[b+3]} !== {6'h02, 32'hFF}) begin failed++; $display("FAIL rc_rd: got %h/%h expected 02/000000ff", wa_q[b+3], wd_q[b+3]); end
      tests_run++; if ({wa_q[b+4], wd_q[b+4]} !== {6'h2B, 32'h11F}) begin failed++; $display("FAIL rsi_csr: got %h/%h expected 2b/0000011f", wa_q[b+4], wd_q[b+4]); end
      tests_run++; if ({wa_q[b+5], wd_q[b+5]} !== {6'h0A, 32'h100}) begin failed++; $display("FAIL rsi_rd: got %h/%h expected 0a/00000100", wa_q[b+5], wd_q[b+5]); end
    end
  endtask

  task automatic test_no_write();
    int lat, acc, b, cb;
    b = wa_q.size(); cb = ccnt;
    issue(3'd7, 12'h304, 5'd0, 32'hFFFFFFFF, 5'd0, lat, acc);
    tests_run++; if (ifc.rsp_illegal !== 1'b0) begin failed++; $display("FAIL rci0_illegal: got %b expected 0", ifc.rsp_illegal); end
    repeat (2) @(negedge clock);
    tests_run++; if (wa_q.size() != b) begin failed++; $display("FAIL rci0_writes: got %0d expected 0", wa_q.size() - b); end
    tests_run++; if (ccnt - cb != 1) begin failed++; $display("FAIL rci0_complete: got %0d expected 1", ccnt - cb); end
  endtask

  task automatic test_illegal();
    int lat, acc, b, cb;
    logic [2:0]  ops  [3] = '{3'd1, 3'd0, 3'd4};
    logic [11:0] csrs [3] = '{12'h7C0, 12'h300, 12'h300};
    for (int i = 0; i < 3; i++) begin
      b = wa_q.size(); cb = ccnt;
      issue(ops[i], csrs[i], 5'd4, 32'h1234, 5'd6, lat, acc);
      tests_run++; if (lat != 2) begin failed++; $display("FAIL ill%0d_latency: got %0d expected 2", i, lat); end
      tests_run++; if (ifc.rsp_illegal !== 1'b1) begin failed++; $display("FAIL ill%0d_flag: got %b expected 1", i, ifc.rsp_illegal); end
      repeat (2) @(negedge clock);
      tests_run++; if (wa_q.size() != b) begin failed++; $display("FAIL ill%0d_writes: got %0d expected 0", i, wa_q.size() - b); end
      tests_run++; if (ccnt != cb) begin failed++; $display("FAIL ill%0d_complete: got %0d expected 0", i, ccnt - cb); end
    end
  endtask

  task automatic test_readonly();
    int lat, acc, b;
    rf[6'h27] = 32'h1234;
    b = wa_q.size();
    issue(3'd1, 12'hF14, 5'd9, 32'h55, 5'd4, lat, acc);
    repeat (2) @(negedge clock);
`ifdef FWRISC_CSR_ROCHECK_EN
    tests_run++; if (wa_q.size() != b) begin failed++; $display("FAIL ro_rw_writes: got %0d expected 0", wa_q.size() - b); end
`else
    tests_run++;
    if (wa_q.size() - b != 2) begin failed++; $display("FAIL ro_rw_wcount: got %0d expected 2", wa_q.size() - b); end
    else begin
      tests_run++; if ({wa_q[b], wd_q[b]} !== {6'h27, 32'h55}) begin failed++; $display("FAIL ro_rw_csr: got %h/%h expected 27/00000055", wa_q[b], wd_q[b]); end
      tests_run++; if ({wa_q[b+1], wd_q[b+1]} !== {6'h04, 32'h1234}) begin failed++; $display("FAIL ro_rw_rd: got %h/%h expected 04/00001234", wa_q[b+1], wd_q[b+1]); end
    end
`endif
    b = wa_q.size();
    issue(3'd2, 12'hF14, 5'd0, 32'hFFFF, 5'd6, lat, acc);
    tests_run++; if (ifc.rsp_illegal !== 1'b0) begin failed++; $display("FAIL ro_rs0_illegal: got %b expected 0", ifc.rsp_illegal); end
    repeat (2) @(negedge clock);
    tests_run++;
    if (wa_q.size() - b != 1) begin failed++; $display("FAIL ro_rs0_wcount: got %0d expected 1", wa_q.size() - b); end
    else begin
      tests_run++; if ({wa_q[b], wd_q[b]} !== {6'h06, 32'h1234}) begin failed++; $display("FAIL ro_rs0_rd: got %h/%h expected 06/00001234", wa_q[b], wd_q[b]); end
    end
  endtask

  task automatic test_hold();
    int lat, acc, cb;
    cb = ccnt;
    ifc.rsp_ready = 1'b0;
    issue(3'd1, 12'h7C0, 5'd1, 32'h1, 5'd1, lat, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests_run++;
      if ({ifc.rsp_valid, ifc.rsp_illegal, ifc.req_ready} !== 3'b110) begin
        failed++; $display("FAIL hold_cycle%0d: got %b expected 110", i, {ifc.rsp_valid, ifc.rsp_illegal, ifc.req_ready});
      end
    end
    ifc.rsp_ready = 1'b1;
    repeat (2) @(negedge clock);
    tests_run++;
    if ({ifc.rsp_valid, ifc.req_ready} !== 2'b01) begin failed++; $display("FAIL hold_release: got %b expected 01", {ifc.rsp_valid, ifc.req_ready}); end
    tests_run++; if (ccnt != cb) begin failed++; $display("FAIL hold_complete: got %0d expected 0", ccnt - cb); end
  endtask

  task automatic test_back_to_back();
    int lat, acc_a, acc_b, b, cb;
    rf[6'h2F] = 32'hCAFE;
    b = wa_q.size(); cb = ccnt;
    issue(3'd2, 12'h343, 5'd0, 32'h0, 5'd9, lat, acc_a);
    @(negedge clock);
    tests_run++; if (ifc.req_ready !== 1'b1) begin failed++; $display("FAIL b2b_ready: got %b expected 1", ifc.req_ready); end
    issue(3'd5, 12'h344, 5'h15, 32'h0, 5'd0, lat, acc_b);
    tests_run++; if (acc_b - acc_a != 5) begin failed++; $display("FAIL b2b_spacing: got %0d expected 5", acc_b - acc_a); end
    repeat (2) @(negedge clock);
    tests_run++;
    if (wa_q.size() - b != 2) begin failed++; $display("FAIL b2b_wcount: got %0d expected 2", wa_q.size() - b); end
    else begin
      tests_run++; if ({wa_q[b], wd_q[b]} !== {6'h09, 32'hCAFE}) begin failed++; $display("FAIL b2b_a_rd: got %h/%h expected 09/0000cafe", wa_q[b], wd_q[b]); end
      tests_run++; if ({wa_q[b+1], wd_q[b+1]} !== {6'h30, 32'h15}) begin failed++; $display("FAIL b2b_b_csr: got %h/%h expected 30/00000015", wa_q[b+1], wd_q[b+1]); end
    end
    tests_run++; if (ccnt - cb != 2) begin failed++; $display("FAIL b2b_complete: got %0d expected 2", ccnt - cb); end
  endtask

  task automatic test_reset_mid();
    int b;
    b = wa_q.size();
    ifc.req_op = 3'd1; ifc.req_csr = 12'h342; ifc.req_rs1 = 5'd2; ifc.req_rs1_data = 32'hA5A5; ifc.req_rd = 5'd8;
    ifc.req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock); ifc.req_valid = 1'b0;
    @(negedge clock);
    tests_run++; if (ifc.rd_wen !== 1'b1) begin failed++; $display("FAIL mid_wcsr_wen: got %b expected 1", ifc.rd_wen); end
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if ({ifc.rd_wen, ifc.req_ready, ifc.rsp_valid} !== 3'b000) begin failed++; $display("FAIL mid_reset_out: got %b expected 000", {ifc.rd_wen, ifc.req_ready, ifc.rsp_valid}); end
    reset = 1'b0;
    @(negedge clock);
    tests_run++; if (ifc.req_ready !== 1'b1) begin failed++; $display("FAIL mid_idle: got %b expected 1", ifc.req_ready); end
    repeat (4) @(negedge clock);
    tests_run++; if (wa_q.size() - b != 1) begin failed++; $display("FAIL mid_writes: got %0d expected 1", wa_q.size() - b); end
  endtask

  initial begin
    tests_run = 0; failed = 0; cyc = 0; ccnt = 0;
    for (int i = 0; i < 64; i++) rf[i] = 32'h0;
    ifc.req_valid = 1'b0; ifc.req_op = 3'd0; ifc.req_csr = 12'h000; ifc.req_rs1 = 5'd0;
    ifc.req_rs1_data = 32'h0; ifc.req_rd = 5'd0; ifc.rsp_ready = 1'b1;
    test_reset();
    test_csrrw();
    test_set_clear();
    test_no_write();
    test_illegal();
    test_readonly();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
